wshb_arbiter_n: RTL and testbench
=================================

WSHB_ARBITER_N -- requirements
Module: wshb_arbiter_n

Interface
REQ-001 SHALL have parameter NM, default 2, number of Wishbone masters (2..8).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width (sel width DW/8).
REQ-004 SHALL have parameter MODE, default 1, 0 = fixed priority (index 0 highest), 1 = round-robin.
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum wait cycles for ack/err/rty before abort (>=2).
REQ-006 SHALL have port clk, in, 1, single clock; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port rst_n, in, 1, asynchronous active-low reset.
REQ-008 SHALL have ports s_cyc, s_stb, s_we, in, NM, per-master strobes.
REQ-009 SHALL have ports s_adr, s_dat_ms, s_sel, s_cti, s_bte, in, NM x AW / DW / DW/8 / 3 / 2, per-master request fields.
REQ-010 SHALL have ports s_ack, s_err, s_rty, out, NM; s_dat_sm, out, DW, shared read data.
REQ-011 SHALL have ports m_cyc, m_stb, m_we, m_adr, m_dat_ms, m_sel, m_cti, m_bte, out, toward the single slave (SDRAM controller).
REQ-012 SHALL have ports m_ack, m_err, m_rty, in, 1; m_dat_sm, in, DW.
REQ-013 SHALL have port grant, out, NM, one-hot registered grant; gnt_id, out, $clog2(NM), its index.
REQ-014 SHALL have port timeout_evt, out, 1, one-cycle pulse on abort.

Function
REQ-015 SHALL implement FSM IDLE, GRANT, ABORT, DRAIN.
REQ-016 IDLE: if any s_cyc high, SHALL select a winner and enter GRANT next edge with grant registered; grant latency exactly 1 cycle from s_cyc.
REQ-017 MODE=1: SHALL select the first requester at or after pointer, wrapping NM-1 to 0; pointer SHALL become winner+1 (mod NM) on each grant.
REQ-018 MODE=0: SHALL select the lowest-index requester; pointer unused.
REQ-019 GRANT: m_* SHALL combinationally equal the granted master's s_*; s_ack/s_err/s_rty of the granted master SHALL equal m_ack/m_err/m_rty; all others 0.
REQ-020 s_dat_sm SHALL equal m_dat_sm when state GRANT, else 0.
REQ-021 Grant SHALL be held for the whole cycle (incl. bursts, any cti) until granted s_cyc low; then IDLE next edge, grant 0; new requests arbitrated from IDLE (1 idle cycle between owners).
REQ-022 Wait counter SHALL reset to 0 whenever m_stb low or m_ack|m_err|m_rty high, else increment in GRANT; saturating.
REQ-023 Counter reaching TIMEOUT SHALL move GRANT to ABORT.
REQ-024 ABORT (1 cycle): s_err of granted master SHALL be 1, m_cyc/m_stb 0, timeout_evt 1; then DRAIN.
REQ-025 DRAIN: m_cyc/m_stb 0, all s_ack/s_err/s_rty 0; granted s_cyc low -> IDLE next edge.
REQ-026 Outside GRANT, m_cyc, m_stb, m_we SHALL be 0; m_adr/m_dat_ms/m_sel/m_cti/m_bte 0.
REQ-027 Requests from non-granted masters SHALL be ignored (no ack) until granted; no request lost while s_cyc held.
REQ-028 Simultaneous granted s_cyc fall and counter hit TIMEOUT: cycle end SHALL win (IDLE, no abort).

Reset
REQ-029 rst_n low SHALL asynchronously force state IDLE, grant 0, gnt_id 0, pointer 0, counter 0, timeout_evt 0, all m_* and s_ack/s_err/s_rty 0.
REQ-030 Reset mid-burst SHALL abandon the transfer; first grant after release per REQ-016.

Structure
REQ-031 Package wshb_arb_pkg SHALL hold the FSM state enum and CTI constants (CLASSIC 3'b000, INCR 3'b010, END 3'b111).
REQ-032 Winner selection SHALL be sub-module rr_picker (req, pointer, MODE -> one-hot winner, index).

Verification
REQ-033 NM=2, MODE=1: masters 0 and 1 raise s_cyc same cycle after reset -> grant=01 next cycle; after 0 drops cyc, 1 idle cycle, then grant=10.
REQ-034 NM=4, MODE=1: all four request continuously, single-beat cycles -> grant order 0,1,2,3,0.
REQ-035 NM=4, MODE=0: masters 1 and 3 request -> grant 1 each time while 1 requests; 3 starves.
REQ-036 8-beat INCR burst from master 2 with master 0 requesting -> grant stays 2 across all 8 acks until cti=END and cyc drop.
REQ-037 TIMEOUT=4, slave never acks -> after 4 wait cycles s_err pulse 1 cycle to granted master, timeout_evt=1, m_cyc=0; IDLE after master drops cyc.
REQ-038 rst_n low during GRANT -> grant=0, m_cyc=0 same cycle (asynchronous).

Source files
------------

// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the N-master Wishbone arbiter.
// Holds the arbiter FSM encoding and the Wishbone cycle-type identifiers.
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ABORT = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

endpackage

// File: rtl/wshb_arbiter_n_rr_picker.sv
// Winner selection for the arbiter: fixed priority (MODE=0) or round-robin
// starting at the pointer (MODE=1); returns one-hot winner and its index.
module rr_picker #(
    parameter int unsigned NM   = 2,
    parameter int unsigned MODE = 1,
    localparam int unsigned IW  = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic [NM-1:0] i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [NM-1:0] o_win_oh,
    output logic [IW-1:0] o_win_idx
);

    logic          w_found;
    logic [IW-1:0] w_cand;

    always_comb begin
        o_win_oh  = '0;
        o_win_idx = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            w_cand = (MODE == 1) ? IW'((32'(i_ptr) + i) % NM) : IW'(i);
            if (!w_found && i_req[w_cand]) begin
                w_found          = 1'b1;
                o_win_oh[w_cand] = 1'b1;
                o_win_idx        = w_cand;
            end
        end
    end

endmodule

// File: rtl/wshb_arbiter_n.sv
// N-master to single-slave Wishbone arbiter with registered grant, whole-cycle
// ownership and a wait-state watchdog that aborts a stalled slave with s_err.
module wshb_arbiter_n #(
    parameter int unsigned NM      = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MODE    = 1,
    parameter int unsigned TIMEOUT = 255,
    localparam int unsigned IW     = $clog2(NM),
    localparam int unsigned SW     = DW / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NM-1:0]    s_cyc,
    input  logic [NM-1:0]    s_stb,
    input  logic [NM-1:0]    s_we,
    input  logic [NM*AW-1:0] s_adr,
    input  logic [NM*DW-1:0] s_dat_ms,
    input  logic [NM*SW-1:0] s_sel,
    input  logic [NM*3-1:0]  s_cti,
    input  logic [NM*2-1:0]  s_bte,
    output logic [NM-1:0]    s_ack,
    output logic [NM-1:0]    s_err,
    output logic [NM-1:0]    s_rty,
    output logic [DW-1:0]    s_dat_sm,
    output logic             m_cyc,
    output logic             m_stb,
    output logic             m_we,
    output logic [AW-1:0]    m_adr,
    output logic [DW-1:0]    m_dat_ms,
    output logic [SW-1:0]    m_sel,
    output logic [2:0]       m_cti,
    output logic [1:0]       m_bte,
    input  logic             m_ack,
    input  logic             m_err,
    input  logic             m_rty,
    input  logic [DW-1:0]    m_dat_sm,
    output logic [NM-1:0]    grant,
    output logic [IW-1:0]    gnt_id,
    output logic             timeout_evt
);

    import wshb_arb_pkg::*;

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    arb_state_t    r_state;
    logic [NM-1:0] r_grant;
    logic [IW-1:0] r_gnt_id;
    logic [IW-1:0] r_ptr;
    logic [CW-1:0] r_wait;
    logic          r_tevt;

    logic [NM-1:0] w_win_oh;
    logic [IW-1:0] w_win_idx;
    logic          w_resp;
    logic          w_own_cyc;
    logic          w_hit;

    rr_picker #(
        .NM   (NM),
        .MODE (MODE)
    ) u_picker (
        .i_req     (s_cyc),
        .i_ptr     (r_ptr),
        .o_win_oh  (w_win_oh),
        .o_win_idx (w_win_idx)
    );

    assign w_resp    = m_ack | m_err | m_rty;
    assign w_own_cyc = s_cyc[r_gnt_id];
    // Abort is decided on the cycle the counter would step onto TIMEOUT.
    assign w_hit     = m_stb && !w_resp && (r_wait == CW'(TIMEOUT - 1));

    assign grant       = r_grant;
    assign gnt_id      = r_gnt_id;
    assign timeout_evt = r_tevt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_gnt_id <= '0;
            r_ptr    <= '0;
            r_wait   <= '0;
            r_tevt   <= 1'b0;
        end else begin
            r_tevt <= 1'b0;

            if (r_state == ST_GRANT && m_stb && !w_resp) begin
                if (r_wait != CW'(TIMEOUT))
                    r_wait <= r_wait + 1'b1;
            end else begin
                r_wait <= '0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (|s_cyc) begin
                        r_state  <= ST_GRANT;
                        r_grant  <= w_win_oh;
                        r_gnt_id <= w_win_idx;
                        if (MODE == 1)
                            r_ptr <= (w_win_idx == IW'(NM - 1)) ? '0 : w_win_idx + IW'(1);
                    end
                end
                ST_GRANT: begin
                    // Cycle end takes precedence over a simultaneous timeout.
                    if (!w_own_cyc) begin
                        r_state  <= ST_IDLE;
                        r_grant  <= '0;
                        r_gnt_id <= '0;
                    end else if (w_hit) begin
                        r_state <= ST_ABORT;
                        r_tevt  <= 1'b1;
                    end
                end
                ST_ABORT: r_state <= ST_DRAIN;
                ST_DRAIN: begin
                    if (!w_own_cyc) begin
                        r_state  <= ST_IDLE;
                        r_grant  <= '0;
                        r_gnt_id <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        m_cyc    = 1'b0;
        m_stb    = 1'b0;
        m_we     = 1'b0;
        m_adr    = '0;
        m_dat_ms = '0;
        m_sel    = '0;
        m_cti    = '0;
        m_bte    = '0;
        s_ack    = '0;
        s_err    = '0;
        s_rty    = '0;
        s_dat_sm = '0;
        case (r_state)
            ST_GRANT: begin
                m_cyc    = s_cyc[r_gnt_id];
                m_stb    = s_stb[r_gnt_id];
                m_we     = s_we[r_gnt_id];
                m_adr    = s_adr[32'(r_gnt_id) * AW +: AW];
                m_dat_ms = s_dat_ms[32'(r_gnt_id) * DW +: DW];
                m_sel    = s_sel[32'(r_gnt_id) * SW +: SW];
                m_cti    = s_cti[32'(r_gnt_id) * 3 +: 3];
                m_bte    = s_bte[32'(r_gnt_id) * 2 +: 2];
                s_ack    = r_grant & {NM{m_ack}};
                s_err    = r_grant & {NM{m_err}};
                s_rty    = r_grant & {NM{m_rty}};
                s_dat_sm = m_dat_sm;
            end
            ST_ABORT: s_err = r_grant;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wshb_arbiter_n.sv
// Directed bench for wshb_arbiter_n: two-master round-robin, four-master
// round-robin with burst/timeout/reset, and four-master fixed priority.
module tb_wshb_arbiter_n;

    import wshb_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: NM=2, MODE=1, defaults.
    logic [1:0]  a_cyc = '0, a_stb = '0;
    logic [1:0]  a_ack, a_err, a_rty, a_gnt;
    logic [0:0]  a_gid;
    logic [31:0] a_dsm, a_madr, a_mdms;
    logic [3:0]  a_msel;
    logic [2:0]  a_mcti;
    logic [1:0]  a_mbte;
    logic        a_mcyc, a_mstb, a_mwe, a_tevt;

    // Instance RR: NM=4, MODE=1, TIMEOUT=4.
    logic [3:0]   rr_cyc = '0, rr_stb = '0;
    logic [127:0] rr_adr;
    logic [11:0]  rr_cti = {4{CTI_CLASSIC}};
    logic [3:0]   rr_ack, rr_err, rr_rty, rr_gnt;
    logic [1:0]   rr_gid;
    logic [31:0]  rr_dsm, rr_madr, rr_mdms;
    logic [3:0]   rr_msel;
    logic [2:0]   rr_mcti;
    logic [1:0]   rr_mbte;
    logic         rr_mcyc, rr_mstb, rr_mwe, rr_tevt, rr_mack;
    logic         rr_ack_en = 1'b1;

    // Instance FP: NM=4, MODE=0, TIMEOUT=4.
    logic [3:0]  fp_cyc = '0, fp_stb = '0;
    logic [3:0]  fp_ack, fp_err, fp_rty, fp_gnt;
    logic [1:0]  fp_gid;
    logic [31:0] fp_dsm, fp_madr, fp_mdms;
    logic [3:0]  fp_msel;
    logic [2:0]  fp_mcti;
    logic [1:0]  fp_mbte;
    logic        fp_mcyc, fp_mstb, fp_mwe, fp_tevt;

    assign rr_mack = rr_ack_en & rr_mstb;

    wshb_arbiter_n u_a (
        .clk(clk), .rst_n(rst_n),
        .s_cyc(a_cyc), .s_stb(a_stb), .s_we(2'b00), .s_adr(64'h0), .s_dat_ms(64'h0),
        .s_sel(8'h0), .s_cti(6'h0), .s_bte(4'h0),
        .s_ack(a_ack), .s_err(a_err), .s_rty(a_rty), .s_dat_sm(a_dsm),
        .m_cyc(a_mcyc), .m_stb(a_mstb), .m_we(a_mwe), .m_adr(a_madr), .m_dat_ms(a_mdms),
        .m_sel(a_msel), .m_cti(a_mcti), .m_bte(a_mbte),
        .m_ack(a_mstb), .m_err(1'b0), .m_rty(1'b0), .m_dat_sm(32'hD00D_0001),
        .grant(a_gnt), .gnt_id(a_gid), .timeout_evt(a_tevt)
    );

    wshb_arbiter_n #(.NM(4), .MODE(1), .TIMEOUT(4)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .s_cyc(rr_cyc), .s_stb(rr_stb), .s_we(4'h0), .s_adr(rr_adr), .s_dat_ms(128'h0),
        .s_sel(16'h0), .s_cti(rr_cti), .s_bte(8'h0),
        .s_ack(rr_ack), .s_err(rr_err), .s_rty(rr_rty), .s_dat_sm(rr_dsm),
        .m_cyc(rr_mcyc), .m_stb(rr_mstb), .m_we(rr_mwe), .m_adr(rr_madr), .m_dat_ms(rr_mdms),
        .m_sel(rr_msel), .m_cti(rr_mcti), .m_bte(rr_mbte),
        .m_ack(rr_mack), .m_err(1'b0), .m_rty(1'b0), .m_dat_sm(32'hD00D_0002),
        .grant(rr_gnt), .gnt_id(rr_gid), .timeout_evt(rr_tevt)
    );

    wshb_arbiter_n #(.NM(4), .MODE(0), .TIMEOUT(4)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .s_cyc(fp_cyc), .s_stb(fp_stb), .s_we(4'h0), .s_adr(128'h0), .s_dat_ms(128'h0),
        .s_sel(16'h0), .s_cti(12'h0), .s_bte(8'h0),
        .s_ack(fp_ack), .s_err(fp_err), .s_rty(fp_rty), .s_dat_sm(fp_dsm),
        .m_cyc(fp_mcyc), .m_stb(fp_mstb), .m_we(fp_mwe), .m_adr(fp_madr), .m_dat_ms(fp_mdms),
        .m_sel(fp_msel), .m_cti(fp_mcti), .m_bte(fp_mbte),
        .m_ack(fp_mstb), .m_err(1'b0), .m_rty(1'b0), .m_dat_sm(32'hD00D_0003),
        .grant(fp_gnt), .gnt_id(fp_gid), .timeout_evt(fp_tevt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp;
        for (int i = 0; i < 4; i++) rr_adr[i*32 +: 32] = 32'hA000_0000 + 32'(i);

        // Reset state
        #2;
        chk("rst_grant", rr_gnt, 4'b0000);
        chk("rst_gid", rr_gid, 2'd0);
        chk("rst_mcyc", rr_mcyc, 1'b0);
        chk("rst_tevt", rr_tevt, 1'b0);
        chk("rst_a_grant", a_gnt, 2'b00);
        #20 rst_n = 1'b1;
        tick();

        // Two masters, same cycle: grant 0, one idle cycle, then grant 1
        a_cyc = 2'b11; a_stb = 2'b11;
        #1 chk("a_no_grant_yet", a_gnt, 2'b00);
        tick();
        chk("a_grant0", a_gnt, 2'b01);
        chk("a_gid0", a_gid, 1'b0);
        chk("a_mcyc", a_mcyc, 1'b1);
        chk("a_ack0", a_ack, 2'b01);
        chk("a_dat_sm", a_dsm, 32'hD00D_0001);
        a_cyc = 2'b10; a_stb = 2'b10;
        tick();
        chk("a_idle_gap", a_gnt, 2'b00);
        chk("a_idle_dat", a_dsm, 32'h0);
        chk("a_idle_mcyc", a_mcyc, 1'b0);
        tick();
        chk("a_grant1", a_gnt, 2'b10);
        chk("a_ack1", a_ack, 2'b10);
        a_cyc = 2'b00; a_stb = 2'b00;
        tick();
        chk("a_release", a_gnt, 2'b00);

        // Round-robin with four continuous single-beat requesters: 0,1,2,3,0
        rr_cyc = 4'b1111; rr_stb = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp = 4'b0001 << (k % 4);
            chk("rr_order", rr_gnt, exp);
            chk("rr_ack", rr_ack, exp);
            chk("rr_madr", rr_madr, 32'hA000_0000 + 32'(k % 4));
            rr_cyc = ~exp; rr_stb = ~exp;
            tick();
            chk("rr_gap", rr_gnt, 4'b0000);
            rr_cyc = (k < 4) ? 4'b1111 : 4'b0000;
            rr_stb = rr_cyc;
            tick();
        end

        // INCR burst from master 2 while master 0 waits (pointer now at 1)
        rr_cyc = 4'b0101; rr_stb = 4'b0101; rr_cti[8:6] = CTI_INCR;
        tick();
        chk("burst_grant", rr_gnt, 4'b0100);
        for (int b = 0; b < 8; b++) begin
            if (b == 7) rr_cti[8:6] = CTI_END;
            #1;
            chk("burst_hold", rr_gnt, 4'b0100);
            chk("burst_ack", rr_ack, 4'b0100);
            chk("burst_cti", rr_mcti, (b == 7) ? CTI_END : CTI_INCR);
            tick();
        end
        rr_cyc = 4'b0001; rr_stb = 4'b0001; rr_cti = {4{CTI_CLASSIC}};
        tick();
        chk("burst_end_idle", rr_gnt, 4'b0000);
        tick();
        chk("burst_next_owner", rr_gnt, 4'b0001);
        rr_cyc = 4'b0000; rr_stb = 4'b0000;
        tick();

        // Slave never acknowledges: abort after 4 wait cycles
        rr_ack_en = 1'b0;
        rr_cyc = 4'b0010; rr_stb = 4'b0010;
        tick();
        chk("to_grant", rr_gnt, 4'b0010);
        for (int w = 1; w < 4; w++) begin
            tick();
            chk("to_waiting_mcyc", rr_mcyc, 1'b1);
            chk("to_waiting_evt", rr_tevt, 1'b0);
        end
        tick();
        chk("to_evt", rr_tevt, 1'b1);
        chk("to_err", rr_err, 4'b0010);
        chk("to_mcyc", rr_mcyc, 1'b0);
        chk("to_mstb", rr_mstb, 1'b0);
        tick();
        chk("drain_evt", rr_tevt, 1'b0);
        chk("drain_err", rr_err, 4'b0000);
        chk("drain_mcyc", rr_mcyc, 1'b0);
        chk("drain_grant", rr_gnt, 4'b0010);
        rr_cyc = 4'b0000; rr_stb = 4'b0000;
        tick();
        chk("drain_to_idle", rr_gnt, 4'b0000);
        rr_ack_en = 1'b1;

        // Fixed priority: master 1 always beats master 3
        fp_cyc = 4'b1010; fp_stb = 4'b1010;
        tick();
        for (int r = 0; r < 3; r++) begin
            chk("fp_grant1", fp_gnt, 4'b0010);
            chk("fp_ack1", fp_ack, 4'b0010);
            fp_cyc = 4'b1000; fp_stb = 4'b1000;
            tick();
            chk("fp_gap", fp_gnt, 4'b0000);
            fp_cyc = 4'b1010; fp_stb = 4'b1010;
            tick();
        end
        chk("fp_grant1_again", fp_gnt, 4'b0010);
        fp_cyc = 4'b1000; fp_stb = 4'b1000;
        tick();
        tick();
        chk("fp_grant3", fp_gnt, 4'b1000);
        fp_cyc = 4'b0000; fp_stb = 4'b0000;
        tick();

        // Asynchronous reset while granted (pointer is 2 here)
        rr_cyc = 4'b0001; rr_stb = 4'b0001;
        tick();
        chk("rst_pre_grant", rr_gnt, 4'b0001);
        chk("rst_pre_mcyc", rr_mcyc, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_grant", rr_gnt, 4'b0000);
        chk("async_rst_mcyc", rr_mcyc, 1'b0);
        chk("async_rst_ack", rr_ack, 4'b0000);
        #2 rst_n = 1'b1;
        rr_cyc = 4'b0011; rr_stb = 4'b0011;
        tick();
        chk("post_rst_ptr0", rr_gnt, 4'b0001);
        rr_cyc = 4'b0000; rr_stb = 4'b0000;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
